z80_bus_master: RTL and testbench

//  Debug-host bus master, directly upstream of the SRAM/level-shifter decode stage.

---
 rtl/z80_bus_master.sv | 152 +++++++++++++++
 tb/tb_z80_bus_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_master.sv
// Debug-host Z80 bus master: requests the bus, runs byte SRAM cycles, releases when idle.
// Optional Z80BM_AUTO_INC_EN adds cmd_seq for sequential (pointer + 1) addressing.
module z80_bus_master #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned ACK_TIMEOUT  = 255,
    parameter int unsigned SETUP_CYC    = 1,
    parameter int unsigned STROBE_CYC   = 2,
    parameter int unsigned HOLD_CYC     = 1,
    parameter int unsigned IDLE_RELEASE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
`ifdef Z80BM_AUTO_INC_EN
    input  logic        cmd_seq,
`endif
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        err_timeout,
    output logic        busrq_n,
    input  logic        busak_n,
    output logic        bsrq,
    output logic [15:0] a_out,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic [7:0]  d_in,
    output logic        mreq_n,
    output logic        rd_n,
    output logic        wr_n
);

    typedef enum logic [2:0] {
        StIdle, StReq, StOwn, StSetup, StStrobe, StHold, StRelease
    } state_e;

    state_e                 state_q, state_d;
    logic [15:0]            cnt_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [15:0]            addr_q, addr_eff;
    logic [7:0]             wdata_q, rd_q, rdata_q;
    logic                   we_q, rsp_q;
    logic                   ak_lost, in_cycle, owned, lost, accept, req_expire, phase_done;
    logic                   strobe;

    // Synchronised busak_n: 1 means the Z80 has not granted (or has taken back) the bus.
    assign ak_lost = sync_q[SYNC_STAGES-1];

`ifdef Z80BM_AUTO_INC_EN
    logic [15:0] ptr_q;
    assign addr_eff = cmd_seq ? ptr_q + 16'd1 : cmd_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= addr_eff;
        end
    end
`else
    assign addr_eff = cmd_addr;
`endif

    always_comb begin
        in_cycle   = (state_q == StSetup) || (state_q == StStrobe) || (state_q == StHold);
        owned      = in_cycle || (state_q == StOwn);
        lost       = owned && ak_lost;
        accept     = (state_q == StOwn) && !ak_lost && cmd_valid;
        req_expire = (state_q == StReq) && ak_lost && (cnt_q == 16'(ACK_TIMEOUT - 1));
        phase_done = 1'b0;
        unique case (state_q)
            StSetup:  phase_done = (cnt_q == 16'(SETUP_CYC - 1));
            StStrobe: phase_done = (cnt_q == 16'(STROBE_CYC - 1));
            StHold:   phase_done = (cnt_q == 16'(HOLD_CYC - 1));
            default:  phase_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sync_q  <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d == state_q) ? cnt_q + 16'd1 : '0;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], busak_n};
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (cmd_valid) state_d = StReq;
            StReq: begin
                if (!ak_lost) state_d = StOwn;
                else if (req_expire) state_d = StIdle;
            end
            StOwn: begin
                if (accept) state_d = StSetup;
                else if (cnt_q == 16'(IDLE_RELEASE - 1)) state_d = StRelease;
            end
            StSetup:   if (phase_done) state_d = StStrobe;
            StStrobe:  if (phase_done) state_d = StHold;
            StHold:    if (phase_done) state_d = StOwn;
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        // Losing the grant aborts whatever is in flight without a response.
        if (lost) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            rdata_q <= '0;
            rsp_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= addr_eff;
                wdata_q <= cmd_wdata;
                we_q    <= cmd_we;
            end
            if ((state_q == StStrobe) && phase_done && !we_q) rd_q <= d_in;
            rsp_q <= (state_q == StHold) && (state_d == StOwn);
            if ((state_q == StHold) && (state_d == StOwn) && !we_q) rdata_q <= rd_q;
        end
    end

    always_comb begin
        strobe      = (state_q == StStrobe) && !ak_lost;
        cmd_ready   = ((state_q == StOwn) && !ak_lost) || req_expire;
        err_timeout = req_expire || lost;
        busrq_n     = (state_q == StIdle);
        bsrq        = owned && !ak_lost;
        mreq_n      = !strobe;
        rd_n        = !(strobe && !we_q);
        wr_n        = !(strobe && we_q);
        d_oe        = in_cycle && we_q && !ak_lost;
        a_out       = in_cycle ? addr_q : '0;
        d_out       = (in_cycle && we_q) ? wdata_q : '0;
        rsp_valid   = rsp_q;
        rsp_rdata   = rdata_q;
    end

endmodule

// File: tb/tb_z80_bus_master.sv
// Bench for z80_bus_master: Z80/SRAM responder plus a memory-level reference model.
module tb_z80_bus_master;

    localparam int unsigned SETUP  = 1;
    localparam int unsigned STROBE = 2;
    localparam int unsigned HOLD   = 1;
    localparam int unsigned ACK_TO = 255;
    localparam int unsigned IDLE_R = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
`ifdef Z80BM_AUTO_INC_EN
    logic        cmd_seq = 1'b0;
`endif
    logic        rsp_valid, err_timeout, busrq_n, bsrq, d_oe, mreq_n, rd_n, wr_n;
    logic [7:0]  rsp_rdata, d_out;
    logic [15:0] a_out;
    logic        busak_n = 1'b1;
    logic [7:0]  d_in = 8'h00;

    always #5 clk = ~clk;

    z80_bus_master #(
        .SYNC_STAGES (2),
        .ACK_TIMEOUT (ACK_TO),
        .SETUP_CYC   (SETUP),
        .STROBE_CYC  (STROBE),
        .HOLD_CYC    (HOLD),
        .IDLE_RELEASE(IDLE_R)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
`ifdef Z80BM_AUTO_INC_EN
        .cmd_seq    (cmd_seq),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .err_timeout(err_timeout),
        .busrq_n    (busrq_n),
        .busak_n    (busak_n),
        .bsrq       (bsrq),
        .a_out      (a_out),
        .d_out      (d_out),
        .d_oe       (d_oe),
        .d_in       (d_in),
        .mreq_n     (mreq_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Z80 grant behaviour and SRAM; both respond half a cycle after the DUT changes.
    logic [7:0] sram [65536];
    int         grant_dly = 3;
    bit         refuse    = 1'b0;
    int         gcnt      = 0;
    int         viol      = 0;

    always @(negedge clk) begin
        if (reset || refuse || busrq_n) begin
            busak_n = 1'b1;
            gcnt    = 0;
        end else if (gcnt >= grant_dly) begin
            busak_n = 1'b0;
        end else begin
            gcnt++;
        end
        if (!mreq_n && !wr_n) sram[a_out] = d_out;
        d_in = (!mreq_n && !rd_n) ? sram[a_out] : 8'($urandom);
        if ((!mreq_n && !bsrq) || (d_oe && !rd_n) || (!rd_n && !wr_n)) viol++;
    end

    logic [7:0]  ref_mem [65536];
    logic [15:0] written [$];
    logic [15:0] mdl_ptr = 16'h0000;

    task automatic check_idle(input string tag);
        check_val({tag, ".ctl"}, {busrq_n, bsrq, mreq_n, rd_n, wr_n, d_oe, rsp_valid,
                                  err_timeout, cmd_ready}, 9'b101110000);
        check_val({tag, ".a"}, a_out, 32'h0);
        check_val({tag, ".d"}, d_out, 32'h0);
    endtask

    // Presents a command at a negedge and waits for its handshake; returns at a negedge.
    task automatic present(input bit we, input logic [15:0] addr, input logic [7:0] wd,
                           input bit seq, output bit got);
        int guard = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wd;
`ifdef Z80BM_AUTO_INC_EN
        cmd_seq   = seq;
`endif
        got = 1'b0;
        while (guard < 400) begin
            if (cmd_ready && !err_timeout) begin
                got = 1'b1;
                break;
            end
            guard++;
            @(negedge clk);
        end
    endtask

    task automatic do_cmd(input bit we, input logic [15:0] addr, input logic [7:0] wd,
                          input bit seq, input string tag);
        logic [15:0] ea;
        logic [15:0] stb_a = '0;
        logic [7:0]  stb_d = '0;
        bit          got, stb_doe = 1'b0, doe_seen = 1'b0;
        int          lat = 0, nstb = 0;
        ea = seq ? mdl_ptr + 16'd1 : addr;
        present(we, addr, wd, seq, got);
        check_val({tag, ".ack"}, got, 1);
        if (got) begin
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                lat = i;
                if (!mreq_n && (we ? !wr_n : !rd_n)) begin
                    nstb++;
                    stb_a   = a_out;
                    stb_d   = d_out;
                    stb_doe = d_oe;
                end
                if (d_oe) doe_seen = 1'b1;
                if (rsp_valid) break;
            end
            check_val({tag, ".lat"}, lat, 1 + SETUP + STROBE + HOLD);
            check_val({tag, ".nstb"}, nstb, STROBE);
            check_val({tag, ".addr"}, stb_a, ea);
            if (we) begin
                ref_mem[ea] = wd;
                written.push_back(ea);
                check_val({tag, ".dout"}, stb_d, wd);
                check_val({tag, ".doe"}, stb_doe, 1);
                check_val({tag, ".sram"}, sram[ea], wd);
            end else begin
                check_val({tag, ".rdoe"}, doe_seen, 0);
                check_val({tag, ".rdata"}, rsp_rdata, ref_mem[ea]);
            end
            mdl_ptr = ea;
        end
    endtask

    initial begin
        bit got;
        int k;
        int nstb, nerr, nrsp;
        bit bsrq_seen;

        reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        repeat (2) @(negedge clk);
        check_idle("rst");
        check_val("rst.rdata", rsp_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Write then read back, bus granted three cycles after the request.
        do_cmd(1'b1, 16'h1234, 8'hA5, 1'b0, "t1");
        check_val("t1.bsrq", bsrq, 1);
        check_val("t1.busrq", busrq_n, 0);
        do_cmd(1'b1, 16'h1235, 8'h5A, 1'b0, "t2w");
        do_cmd(1'b0, 16'h1235, 8'h00, 1'b0, "t2r");
        do_cmd(1'b0, 16'h1234, 8'h00, 1'b0, "t2r2");

        // Random traffic; long gaps let the bus be released and re-requested.
        for (int n = 0; n < 40; n++) begin
            bit          we;
            logic [15:0] ad;
            we = (written.size() == 0) || ($urandom_range(0, 1) == 1);
            ad = we ? 16'($urandom) : written[$urandom_range(0, written.size() - 1)];
            grant_dly = $urandom_range(0, 5);
            do_cmd(we, ad, 8'($urandom), 1'b0, "rnd");
            repeat (($urandom_range(0, 7) == 0) ? 24 : $urandom_range(0, 3)) @(negedge clk);
        end

        // Idle release: bsrq drops IDLE_R cycles after the response, busrq_n one later.
        do_cmd(1'b1, 16'hBEEF, 8'h42, 1'b0, "t4c");
        k = 0;
        while (bsrq && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_val("t4.rel", k, IDLE_R);
        check_val("t4.busrq_rel", busrq_n, 0);
        @(negedge clk);
        check_val("t4.busrq_idle", busrq_n, 1);
        repeat (3) @(negedge clk);

        // Grant never arrives: command is dropped with err_timeout after ACK_TO cycles.
        refuse = 1'b1;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 16'h0001; cmd_wdata = 8'h77;
        k = 0;
        bsrq_seen = 1'b0;
        while (k < 400) begin
            @(negedge clk);
            k++;
            if (bsrq) bsrq_seen = 1'b1;
            if (cmd_ready) break;
        end
        check_val("t3.wait", k, ACK_TO);
        check_val("t3.err", err_timeout, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check_val("t3.busrq", busrq_n, 1);
        check_val("t3.err_pulse", err_timeout, 0);
        check_val("t3.bsrq", bsrq_seen, 0);
        refuse = 1'b0;
        repeat (2) @(negedge clk);

        // Z80 takes the bus back during SETUP: visible (synchronised) in the second strobe.
        grant_dly = 2;
        present(1'b1, 16'h0F0F, 8'h3C, 1'b0, got);
        check_val("t5.ack", got, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        refuse = 1'b1;
        mdl_ptr = 16'h0F0F;
        nstb = 0; nerr = 0; nrsp = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!mreq_n && !wr_n) nstb++;
            if (err_timeout) nerr++;
            if (rsp_valid) nrsp++;
        end
        check_val("t5.nstb", nstb, 1);
        check_val("t5.err", nerr, 1);
        check_val("t5.rsp", nrsp, 0);
        check_idle("t5.end");
        refuse = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a strobe.
        present(1'b1, 16'h2222, 8'h99, 1'b0, got);
        check_val("t5r.ack", got, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        k = 0;
        while (mreq_n && k < 10) begin
            @(negedge clk);
            k++;
        end
        check_val("t5r.strobe", mreq_n, 0);
        reset = 1'b1;
        @(negedge clk);
        check_idle("t5r");
        reset = 1'b0;
        mdl_ptr = 16'h0000;
        repeat (3) @(negedge clk);
        do_cmd(1'b0, 16'h1234, 8'h00, 1'b0, "after_rst");

`ifdef Z80BM_AUTO_INC_EN
        do_cmd(1'b1, 16'hFFFF, 8'h11, 1'b0, "t6a");
        do_cmd(1'b1, 16'h5555, 8'h22, 1'b1, "t6b");
        do_cmd(1'b0, 16'h7777, 8'h00, 1'b1, "t6c");
`endif

        check_val("protocol", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
